// File: rtl/dsi_packet_assembler_pkg.sv
// Shared types and constants for the DSI packet assembler.
// Holds the FSM encoding, the CRC seed and the header byte layout.
package dsi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_PAY  = 2'd2,
      ST_CRC  = 2'd3
   } state_t;

   localparam logic [15:0] CRC_SEED_DEF = 16'hFFFF;

   localparam int HDR_DI    = 0;
   localparam int HDR_WC_LO = 1;
   localparam int HDR_WC_HI = 2;
   localparam int HDR_ECC   = 3;

   // Keep bytes 0..nm1 of a payload word, zero the rest.
   function automatic logic [31:0] pad_mask(input logic [31:0] d, input logic [1:0] nm1);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 4; i++)
         if (i <= int'(nm1)) m[i*8 +: 8] = 8'hFF;
      return d & m;
   endfunction

endpackage

// File: rtl/dsi_packet_assembler_if.sv
// Command, payload and output streams of the DSI packet assembler.
// master = front end / downstream side, slave = the assembler.
interface dsi_packet_assembler_if;
   logic        pkt_valid;
   logic        pkt_ready;
   logic [7:0]  pkt_data_id;
   logic [15:0] pkt_word_count;
   logic        pkt_long;
   logic [31:0] pl_data;
   logic        pl_valid;
   logic        pl_ready;
   logic [31:0] out_data;
   logic [1:0]  out_bytes;
   logic        out_last;
   logic        out_valid;
   logic        out_ready;

   modport master (
      output pkt_valid, pkt_data_id, pkt_word_count, pkt_long, pl_data, pl_valid, out_ready,
      input  pkt_ready, pl_ready, out_data, out_bytes, out_last, out_valid
   );

   modport slave (
      input  pkt_valid, pkt_data_id, pkt_word_count, pkt_long, pl_data, pl_valid, out_ready,
      output pkt_ready, pl_ready, out_data, out_bytes, out_last, out_valid
   );
endinterface

// File: rtl/dsi_packet_assembler_crc.sv
// DSI payload checksum: CRC-16 x^16+x^12+x^5+1, LSB first, no final xor.
// Processes bytes 0..bytes_number of data_in per data_write.
module crc_calculator #(
   parameter logic [15:0] SEED = 16'hFFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        data_write,
   input  logic [1:0]  bytes_number,
   input  logic [31:0] data_in,
   output logic [15:0] crc_output_sync
);
   logic [15:0] crc_q, crc_n;

   always_comb begin
      crc_n = crc_q;
      for (int i = 0; i < 4; i++) begin
         if (i <= int'(bytes_number)) begin
            crc_n = crc_n ^ {8'h00, data_in[i*8 +: 8]};
            for (int b = 0; b < 8; b++)
               crc_n = crc_n[0] ? ((crc_n >> 1) ^ 16'h8408) : (crc_n >> 1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)           crc_q <= SEED;
      else if (clear)      crc_q <= SEED;
      else if (data_write) crc_q <= crc_n;
   end

   assign crc_output_sync = crc_q;
endmodule

// File: rtl/dsi_packet_assembler_ecc.sv
// DSI header ECC over {word_count, data_id}; Hamming-style parity P0..P5.
// P6/P7 are always zero.
module ecc_calc (
   input  logic [23:0] d,
   output logic [7:0]  ecc
);
   assign ecc[0] = ^(d & 24'hF12CB7);
   assign ecc[1] = ^(d & 24'hF2555B);
   assign ecc[2] = ^(d & 24'h749A6D);
   assign ecc[3] = ^(d & 24'hB8E38E);
   assign ecc[4] = ^(d & 24'hDF03F0);
   assign ecc[5] = ^(d & 24'hEFFC00);
   assign ecc[7:6] = 2'b00;
endmodule

// File: rtl/dsi_packet_assembler.sv
// Assembles DSI packets: header (ID, WC, ECC), payload words and CRC footer.
// A single output register feeds the lane distributor with valid/ready flow control.
module dsi_packet_assembler
   import dsi_pkg::*;
#(
   parameter logic [15:0] CRC_SEED = CRC_SEED_DEF,
   parameter bit          ZERO_PAD = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   dsi_packet_assembler_if.slave  bus,
   output logic                   busy
);
   state_t      state, state_n;
   logic [7:0]  id_q;
   logic [15:0] wc_q;
   logic        long_q;
   logic [15:0] remaining;

   logic        load_en, pkt_hs, pl_hs;
   logic        ld, ld_last;
   logic [31:0] ld_data;
   logic [1:0]  ld_bytes, n_m1;
   logic [15:0] n_bytes;
   logic [7:0]  hdr_id, ecc;
   logic [15:0] hdr_wc, crc;
   logic        hdr_long;
   logic [31:0] hdr_word;

   assign load_en       = !bus.out_valid | bus.out_ready;
   assign bus.pkt_ready = (state == ST_IDLE) & !reset;
   assign pkt_hs        = bus.pkt_valid & bus.pkt_ready;
   assign bus.pl_ready  = (state == ST_PAY) & load_en;
   assign pl_hs         = bus.pl_valid & bus.pl_ready;
   assign busy          = (state != ST_IDLE);

   // Header built straight from the command in IDLE so back-to-back packets have no bubble.
   assign hdr_id   = (state == ST_IDLE) ? bus.pkt_data_id    : id_q;
   assign hdr_wc   = (state == ST_IDLE) ? bus.pkt_word_count : wc_q;
   assign hdr_long = (state == ST_IDLE) ? bus.pkt_long       : long_q;

   ecc_calc u_ecc (.d({hdr_wc, hdr_id}), .ecc(ecc));

   always_comb begin
      hdr_word = '0;
      hdr_word[HDR_DI*8    +: 8] = hdr_id;
      hdr_word[HDR_WC_LO*8 +: 8] = hdr_wc[7:0];
      hdr_word[HDR_WC_HI*8 +: 8] = hdr_wc[15:8];
      hdr_word[HDR_ECC*8   +: 8] = ecc;
   end

   assign n_m1    = (remaining > 16'd3) ? 2'd3 : 2'(remaining - 16'd1);
   assign n_bytes = {14'd0, n_m1} + 16'd1;

   crc_calculator #(.SEED(CRC_SEED)) u_crc (
      .clk             (clk),
      .reset           (reset),
      .clear           (pkt_hs),
      .data_write      (pl_hs),
      .bytes_number    (n_m1),
      .data_in         (bus.pl_data),
      .crc_output_sync (crc)
   );

   always_comb begin
      state_n  = state;
      ld       = 1'b0;
      ld_data  = '0;
      ld_bytes = '0;
      ld_last  = 1'b0;
      case (state)
         ST_IDLE, ST_HDR: begin
            if (state == ST_HDR || pkt_hs) begin
               if (load_en) begin
                  ld       = 1'b1;
                  ld_data  = hdr_word;
                  ld_bytes = 2'd3;
                  ld_last  = !hdr_long;
                  if (!hdr_long)            state_n = ST_IDLE;
                  else if (hdr_wc == 16'd0) state_n = ST_CRC;
                  else                      state_n = ST_PAY;
               end else begin
                  state_n = ST_HDR;
               end
            end
         end
         ST_PAY: begin
            if (pl_hs) begin
               ld       = 1'b1;
               ld_data  = ZERO_PAD ? pad_mask(bus.pl_data, n_m1) : bus.pl_data;
               ld_bytes = n_m1;
               state_n  = (remaining == n_bytes) ? ST_CRC : ST_PAY;
            end
         end
         ST_CRC: begin
            if (load_en) begin
               ld       = 1'b1;
               ld_data  = {16'h0000, crc};
               ld_bytes = 2'd1;
               ld_last  = 1'b1;
               state_n  = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_n;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         id_q      <= '0;
         wc_q      <= '0;
         long_q    <= 1'b0;
         remaining <= '0;
      end else if (pkt_hs) begin
         id_q      <= bus.pkt_data_id;
         wc_q      <= bus.pkt_word_count;
         long_q    <= bus.pkt_long;
         remaining <= bus.pkt_word_count;
      end else if (pl_hs) begin
         remaining <= remaining - n_bytes;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_bytes <= '0;
         bus.out_last  <= 1'b0;
      end else if (ld) begin
         bus.out_valid <= 1'b1;
         bus.out_data  <= ld_data;
         bus.out_bytes <= ld_bytes;
         bus.out_last  <= ld_last;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dsi_packet_assembler.sv
// Directed bench for dsi_packet_assembler: header/ECC, payload, CRC footer,
// backpressure, back-to-back commands and reset mid-packet.
module tb_dsi_packet_assembler;
   logic clk = 1'b0;
   logic reset;
   logic busy;

   dsi_packet_assembler_if bus();

   dsi_packet_assembler #(.CRC_SEED(16'hFFFF), .ZERO_PAD(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Output words captured as {last, bytes, data}.
   logic [34:0] q_word[$];
   int          q_cyc[$];
   int          pkt_cyc[$];
   int          stall_viol;
   bit          pl_seen;
   bit          prev_stall;
   logic [34:0] prev_w;
   logic [31:0] pl_q[$];
   bit          bp_run;

   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!bus.out_valid ||
             {bus.out_last, bus.out_bytes, bus.out_data} !== prev_w)) stall_viol++;
         if (bus.pl_ready) pl_seen = 1'b1;
         if (bus.pkt_valid && bus.pkt_ready) pkt_cyc.push_back(cyc);
         if (bus.out_valid && bus.out_ready) begin
            q_word.push_back({bus.out_last, bus.out_bytes, bus.out_data});
            q_cyc.push_back(cyc);
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_w     = {bus.out_last, bus.out_bytes, bus.out_data};
      end
   end

   function automatic logic [34:0] got(input int i);
      return (i < q_word.size()) ? q_word[i] : 35'bx;
   endfunction

   // Bit-serial reference: reflected CCITT, seed FFFF, first nbytes of the word list.
   function automatic logic [15:0] crc_model(input logic [31:0] w[$], input int nbytes);
      logic [15:0] c;
      logic [7:0]  b;
      logic        fb;
      c = 16'hFFFF;
      for (int k = 0; k < nbytes; k++) begin
         b = w[k/4][(k%4)*8 +: 8];
         for (int j = 0; j < 8; j++) begin
            fb = c[0] ^ b[j];
            c  = c >> 1;
            if (fb) c = c ^ 16'h8408;
         end
      end
      return c;
   endfunction

   task automatic clear_mon();
      q_word.delete();
      q_cyc.delete();
      pkt_cyc.delete();
      stall_viol = 0;
      pl_seen    = 1'b0;
   endtask

   task automatic send_cmd(input logic [7:0] id, input logic [15:0] wc, input logic lng);
      int t;
      bus.pkt_data_id    = id;
      bus.pkt_word_count = wc;
      bus.pkt_long       = lng;
      bus.pkt_valid      = 1'b1;
      t = 0;
      forever begin
         @(negedge clk);
         if (bus.pkt_ready) break;
         t++;
         if (t > 300) begin
            errors++; checks++;
            $display("FAIL cmd_timeout: pkt_ready=%0b never 1", bus.pkt_ready);
            break;
         end
      end
      @(posedge clk); #1;
      bus.pkt_valid = 1'b0;
   endtask

   task automatic send_payload();
      int t;
      while (pl_q.size() > 0) begin
         bus.pl_valid = 1'b1;
         bus.pl_data  = pl_q.pop_front();
         t = 0;
         forever begin
            @(negedge clk);
            if (bus.pl_ready) break;
            t++;
            if (t > 300) begin
               errors++; checks++;
               $display("FAIL pl_timeout: pl_ready=%0b never 1", bus.pl_ready);
               break;
            end
         end
         @(posedge clk); #1;
      end
      bus.pl_valid = 1'b0;
      bus.pl_data  = '0;
   endtask

   task automatic wait_words(input int n);
      int t;
      t = 0;
      while (q_word.size() < n && t < 400) begin
         @(posedge clk);
         t++;
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.pkt_valid = 0; bus.pkt_data_id = 0; bus.pkt_word_count = 0; bus.pkt_long = 0;
      bus.pl_valid = 0; bus.pl_data = 0; bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
      checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b want 0", bus.out_last); end
      checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data: got %h want 0", bus.out_data); end
      checks++; if (bus.out_bytes !== 2'd0) begin errors++; $display("FAIL rst_out_bytes: got %0d want 0", bus.out_bytes); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (bus.pkt_ready !== 1'b0) begin errors++; $display("FAIL rst_pkt_ready: got %b want 0", bus.pkt_ready); end
      checks++; if (bus.pl_ready !== 1'b0) begin errors++; $display("FAIL rst_pl_ready: got %b want 0", bus.pl_ready); end
      reset = 1'b0;
      #1;
      checks++; if (bus.pkt_ready !== 1'b1) begin errors++; $display("FAIL rst_pkt_ready_after: got %b want 1", bus.pkt_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_short();
      clear_mon();
      send_cmd(8'h05, 16'h0011, 1'b0);
      wait_words(1);
      checks++; if (q_word.size() != 1) begin errors++; $display("FAIL short_count: got %0d want 1", q_word.size()); end
      checks++; if (got(0) !== {1'b1, 2'd3, 32'h36001105}) begin errors++; $display("FAIL short_word: got %h want %h", got(0), {1'b1, 2'd3, 32'h36001105}); end
      checks++; if (pl_seen !== 1'b0) begin errors++; $display("FAIL short_pl_ready: got %b want 0", pl_seen); end
      checks++; if (q_cyc.size() < 1 || pkt_cyc.size() < 1 || q_cyc[0] != pkt_cyc[0] + 1) begin
         errors++; $display("FAIL short_latency: got %0d want %0d", (q_cyc.size() > 0) ? q_cyc[0] : -1, (pkt_cyc.size() > 0) ? pkt_cyc[0] + 1 : -1);
      end
   endtask

   task automatic test_long();
      logic [34:0] exp[5];
      exp[0] = {1'b0, 2'd3, 32'h30000939};
      exp[1] = {1'b0, 2'd3, 32'h34333231};
      exp[2] = {1'b0, 2'd3, 32'h38373635};
      exp[3] = {1'b0, 2'd0, 32'h00000039};
      exp[4] = {1'b1, 2'd1, 32'h00006F91};
      clear_mon();
      pl_q = '{32'h34333231, 32'h38373635, 32'hAABBCC39};
      send_cmd(8'h39, 16'd9, 1'b1);
      send_payload();
      wait_words(5);
      checks++; if (q_word.size() != 5) begin errors++; $display("FAIL long_count: got %0d want 5", q_word.size()); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (got(i) !== exp[i]) begin errors++; $display("FAIL long_word%0d: got %h want %h", i, got(i), exp[i]); end
      end
      checks++; if (q_cyc.size() < 5 || q_cyc[4] - q_cyc[0] != 4) begin
         errors++; $display("FAIL long_no_bubble: got span %0d want 4", (q_cyc.size() >= 5) ? q_cyc[4] - q_cyc[0] : -1);
      end
   endtask

   task automatic test_long_zero();
      clear_mon();
      send_cmd(8'h39, 16'd0, 1'b1);
      wait_words(2);
      checks++; if (q_word.size() != 2) begin errors++; $display("FAIL wc0_count: got %0d want 2", q_word.size()); end
      checks++; if (got(0) !== {1'b0, 2'd3, 32'h0F000039}) begin errors++; $display("FAIL wc0_header: got %h want %h", got(0), {1'b0, 2'd3, 32'h0F000039}); end
      checks++; if (got(1) !== {1'b1, 2'd1, 32'h0000FFFF}) begin errors++; $display("FAIL wc0_footer: got %h want %h", got(1), {1'b1, 2'd1, 32'h0000FFFF}); end
      checks++; if (pl_seen !== 1'b0) begin errors++; $display("FAIL wc0_pl_ready: got %b want 0", pl_seen); end
   endtask

   task automatic test_backpressure();
      logic [31:0] words[$];
      logic [15:0] crc;
      clear_mon();
      for (int i = 0; i < 16; i++) words.push_back($urandom);
      pl_q = words;
      crc = crc_model(words, 64);
      bp_run = 1'b1;
      fork
         begin
            send_cmd(8'h39, 16'd64, 1'b1);
            send_payload();
            wait_words(18);
            bp_run = 1'b0;
         end
         begin
            while (bp_run) begin
               @(posedge clk); #1;
               bus.out_ready = 1'($urandom_range(0, 1));
            end
            bus.out_ready = 1'b1;
         end
      join
      wait_words(18);
      checks++; if (q_word.size() != 18) begin errors++; $display("FAIL bp_count: got %0d want 18", q_word.size()); end
      checks++; if (got(0) !== {1'b0, 2'd3, 32'h25004039}) begin errors++; $display("FAIL bp_header: got %h want %h", got(0), {1'b0, 2'd3, 32'h25004039}); end
      for (int i = 0; i < 16; i++) begin
         checks++; if (got(i + 1) !== {1'b0, 2'd3, words[i]}) begin errors++; $display("FAIL bp_word%0d: got %h want %h", i, got(i + 1), {1'b0, 2'd3, words[i]}); end
      end
      checks++; if (got(17) !== {1'b1, 2'd1, 16'h0000, crc}) begin errors++; $display("FAIL bp_crc: got %h want %h", got(17), {1'b1, 2'd1, 16'h0000, crc}); end
      checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stable: got %0d changes want 0", stall_viol); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] w[$];
      logic [34:0] exp[4];
      w = '{32'h34333231};
      exp[0] = {1'b0, 2'd3, 32'h2C000439};
      exp[1] = {1'b0, 2'd3, 32'h34333231};
      exp[2] = {1'b1, 2'd1, 16'h0000, crc_model(w, 4)};
      exp[3] = {1'b1, 2'd3, 32'h36001105};
      clear_mon();
      pl_q = w;
      fork
         begin
            send_cmd(8'h39, 16'd4, 1'b1);
            send_cmd(8'h05, 16'h0011, 1'b0);
         end
         send_payload();
      join
      wait_words(4);
      checks++; if (q_word.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", q_word.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (got(i) !== exp[i]) begin errors++; $display("FAIL b2b_word%0d: got %h want %h", i, got(i), exp[i]); end
      end
      checks++; if (q_cyc.size() < 4 || q_cyc[3] - q_cyc[0] != 3) begin
         errors++; $display("FAIL b2b_no_gap: got span %0d want 3", (q_cyc.size() >= 4) ? q_cyc[3] - q_cyc[0] : -1);
      end
   endtask

   task automatic test_reset_mid();
      clear_mon();
      pl_q = '{32'h11111111, 32'h22222222};
      send_cmd(8'h39, 16'd16, 1'b1);
      send_payload();
      #2;
      reset = 1'b1;
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %b want 0", bus.out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      checks++; if (bus.pkt_ready !== 1'b1) begin errors++; $display("FAIL rmid_pkt_ready: got %b want 1", bus.pkt_ready); end
      @(posedge clk); #1;
      clear_mon();
      pl_q = '{32'h34333231, 32'h38373635, 32'h00000039};
      send_cmd(8'h39, 16'd9, 1'b1);
      send_payload();
      wait_words(5);
      checks++; if (q_word.size() != 5) begin errors++; $display("FAIL rmid_count: got %0d want 5", q_word.size()); end
      checks++; if (got(4) !== {1'b1, 2'd1, 32'h00006F91}) begin errors++; $display("FAIL rmid_crc: got %h want %h", got(4), {1'b1, 2'd1, 32'h00006F91}); end
   endtask

   initial begin
      test_reset();
      test_short();
      test_long();
      test_long_zero();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
